// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file.
// Holds NUM_REGS registers and exports their contents (reg_q) and per-register write pulses
// (reg_wr) to core logic. AW and W are accepted independently into one-entry holding buffers.
// Writes honour byte-lane strobes. Out-of-range or misaligned accesses return SLVERR.
module axi_lite_regfile #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_REGS   = 16,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                           ACLK,
    input  logic                           ARESETn,
    // write address channel
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    // write data channel
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    // write response channel
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    // read address channel
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    // read data channel
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    // core-side view
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
    output logic [NUM_REGS-1:0]            reg_wr
);

    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam int unsigned AddrLsb   = $clog2(StrbWidth);
    localparam int unsigned IdxWidth  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [ADDR_WIDTH-1:0] RegCount = ADDR_WIDTH'(NUM_REGS);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef struct packed {
        logic                err;
        logic [IdxWidth-1:0] idx;
    } dec_t;

    // Address -> register index, flagging below-base, past-the-end and misaligned accesses.
    function automatic dec_t decode(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] offset;
        logic [ADDR_WIDTH-1:0] word;
        dec_t                  d;
        offset = addr - BASE_ADDR;
        word   = offset >> AddrLsb;
        d.err  = (addr < BASE_ADDR) || (word >= RegCount) || (offset[AddrLsb-1:0] != '0);
        d.idx  = word[IdxWidth-1:0];
        return d;
    endfunction

    logic                  aw_held;
    logic                  w_held;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [StrbWidth-1:0]  w_strb_q;
    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];

    logic aw_hs;
    logic w_hs;
    logic ar_hs;
    logic commit;
    dec_t wr_dec;
    dec_t rd_dec;

    // READY outputs are forced low while reset is asserted.
    assign AWREADY = ARESETn & ~aw_held & ~BVALID;
    assign WREADY  = ARESETn & ~w_held & ~BVALID;
    assign ARREADY = ARESETn & ~RVALID;

    assign aw_hs  = AWVALID & AWREADY;
    assign w_hs   = WVALID & WREADY;
    assign ar_hs  = ARVALID & ARREADY;
    assign commit = aw_held & w_held & ~BVALID;

    // Decode the buffered write address and the live read address.
    always_comb begin
        wr_dec = decode(aw_addr_q);
        rd_dec = decode(ARADDR);
    end

    // Write channel: holding buffers, commit, B response and write pulses.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            aw_addr_q <= '0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            BVALID    <= 1'b0;
            BRESP     <= RespOkay;
            reg_wr    <= '0;
        end else begin
            reg_wr <= '0;
            if (aw_hs) begin
                aw_held   <= 1'b1;
                aw_addr_q <= AWADDR;
            end
            if (w_hs) begin
                w_held   <= 1'b1;
                w_data_q <= WDATA;
                w_strb_q <= WSTRB;
            end
            if (commit) begin
                // Buffers cannot refill this cycle: their READYs are low while held.
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                BVALID  <= 1'b1;
                if (wr_dec.err) begin
                    BRESP <= RespSlverr;
                end else begin
                    BRESP              <= RespOkay;
                    reg_wr[wr_dec.idx] <= 1'b1;
                end
            end else if (BVALID && BREADY) begin
                BVALID <= 1'b0;
            end
        end
    end

    // Register storage: byte-lane merge of the committed write.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit && !wr_dec.err) begin
            for (int k = 0; k < StrbWidth; k++) begin
                if (w_strb_q[k]) begin
                    regs_q[wr_dec.idx][k*8 +: 8] <= w_data_q[k*8 +: 8];
                end
            end
        end
    end

    // Read channel: sample the pre-write register state on AR handshake, hold until RREADY.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            RVALID <= 1'b0;
            RDATA  <= '0;
            RRESP  <= RespOkay;
        end else if (ar_hs) begin
            RVALID <= 1'b1;
            if (rd_dec.err) begin
                RDATA <= '0;
                RRESP <= RespSlverr;
            end else begin
                RDATA <= regs_q[rd_dec.idx];
                RRESP <= RespOkay;
            end
        end else if (RVALID && RREADY) begin
            RVALID <= 1'b0;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flatten
        assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed testbench for axi_lite_regfile: a 32-bit/16-register build for most scenarios
// and a 64-bit build for the read/write collision case.
module tb_axi_lite_regfile;

    logic ACLK = 1'b0;
    logic ARESETn;
    always #5 ACLK = ~ACLK;

    // 32-bit instance signals
    logic [31:0]  awaddr, araddr, wdata, rdata;
    logic [3:0]   wstrb;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [1:0]   bresp, rresp;
    logic [511:0] reg_q32;
    logic [15:0]  reg_wr32;

    // 64-bit instance signals
    logic [31:0]   awaddr64, araddr64;
    logic [63:0]   wdata64, rdata64;
    logic [7:0]    wstrb64;
    logic          awvalid64, awready64, wvalid64, wready64, bvalid64, bready64;
    logic          arvalid64, arready64, rvalid64, rready64;
    logic [1:0]    bresp64, rresp64;
    logic [1023:0] reg_q64;
    logic [15:0]   reg_wr64;

    axi_lite_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16), .BASE_ADDR(32'h0)
    ) u_dut32 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
        .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
        .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
        .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
        .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
        .reg_q(reg_q32), .reg_wr(reg_wr32)
    );

    axi_lite_regfile #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .NUM_REGS(16), .BASE_ADDR(32'h0)
    ) u_dut64 (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .AWADDR(awaddr64), .AWVALID(awvalid64), .AWREADY(awready64),
        .WDATA(wdata64), .WSTRB(wstrb64), .WVALID(wvalid64), .WREADY(wready64),
        .BRESP(bresp64), .BVALID(bvalid64), .BREADY(bready64),
        .ARADDR(araddr64), .ARVALID(arvalid64), .ARREADY(arready64),
        .RDATA(rdata64), .RRESP(rresp64), .RVALID(rvalid64), .RREADY(rready64),
        .reg_q(reg_q64), .reg_wr(reg_wr64)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          pulse_cnt = 0;
    logic [31:0] exp_regs [16];

    // Count cycles in which any 32-bit register write pulse is high.
    always @(negedge ACLK) begin
        if (reg_wr32 != 16'h0) pulse_cnt = pulse_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("%s reg_q[%0d]", tag, i), 64'(reg_q32[i*32 +: 32]),
                     64'(exp_regs[i]));
        end
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, output logic [1:0] resp);
        int   n;
        logic aw_hs, w_hs;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            aw_hs = awvalid & awready;
            w_hs  = wvalid & wready;
            tick();
            n++;
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        n = 0;
        while (!bvalid && n < 20) begin
            tick();
            n++;
        end
        check_eq("bvalid_wait", 64'(bvalid), 64'(1));
        resp = bresp;
        tick();
    endtask

    task automatic rd32(input logic [31:0] addr, output logic [31:0] data,
                        output logic [1:0] resp);
        int n;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        while (!arready && n < 20) begin
            tick();
            n++;
        end
        tick();
        arvalid = 1'b0;
        n = 0;
        while (!rvalid && n < 20) begin
            tick();
            n++;
        end
        check_eq("rvalid_wait", 64'(rvalid), 64'(1));
        data = rdata;
        resp = rresp;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int          p0;

        for (int i = 0; i < 16; i++) exp_regs[i] = 32'h0;

        // Reset with every VALID asserted.
        ARESETn = 1'b0;
        awaddr = 32'h8; wdata = 32'hFFFF_FFFF; wstrb = 4'hF; araddr = 32'h8;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b1; rready = 1'b1;
        awaddr64 = 32'h8; wdata64 = '1; wstrb64 = 8'hFF; araddr64 = 32'h8;
        awvalid64 = 1'b1; wvalid64 = 1'b1; arvalid64 = 1'b1; bready64 = 1'b1; rready64 = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check_eq("rst_readies", 64'({awready, wready, arready}), 64'(0));
            check_eq("rst_valids", 64'({bvalid, rvalid}), 64'(0));
            check_eq("rst_readies64", 64'({awready64, wready64, arready64}), 64'(0));
        end
        check_eq("rst_reg_wr", 64'(reg_wr32), 64'(0));
        check_eq("rst_reg_q64_or", 64'(|reg_q64), 64'(0));
        check_regs("rst");

        ARESETn = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        awvalid64 = 1'b0; wvalid64 = 1'b0; arvalid64 = 1'b0;
        #1;
        check_eq("post_rst_readies", 64'({awready, wready, arready}), 64'(3'b111));
        check_eq("post_rst_readies64", 64'({awready64, wready64, arready64}), 64'(3'b111));

        // Full write with exact timing: AW+W same cycle, BVALID two cycles later.
        tick();
        p0 = pulse_cnt;
        awaddr = 32'h08; wdata = 32'hDEAD_BEEF; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0;
        check_eq("wr_c1_bvalid", 64'(bvalid), 64'(0));
        check_eq("wr_c1_readies", 64'({awready, wready}), 64'(0));
        tick();
        check_eq("wr_c2_bvalid", 64'(bvalid), 64'(1));
        check_eq("wr_c2_bresp", 64'(bresp), 64'(2'b00));
        check_eq("wr_c2_reg_wr", 64'(reg_wr32), 64'(16'h0004));
        check_eq("wr_c2_reg2", 64'(reg_q32[2*32 +: 32]), 64'(32'hDEAD_BEEF));
        tick();
        check_eq("wr_c3_bvalid", 64'(bvalid), 64'(0));
        check_eq("wr_c3_reg_wr", 64'(reg_wr32), 64'(0));
        check_eq("wr_pulses", 64'(pulse_cnt - p0), 64'(1));
        exp_regs[2] = 32'hDEAD_BEEF;
        rd32(32'h08, d, r);
        check_eq("rd_reg2_data", 64'(d), 64'(32'hDEAD_BEEF));
        check_eq("rd_reg2_resp", 64'(r), 64'(2'b00));

        // Byte strobes: lanes 0 and 2 replaced.
        wr32(32'h08, 32'h1122_3344, 4'b0101, r);
        check_eq("strb_bresp", 64'(r), 64'(2'b00));
        exp_regs[2] = 32'hDE22_BE44;
        rd32(32'h08, d, r);
        check_eq("strb_rdata", 64'(d), 64'(32'hDE22_BE44));

        // Zero strobe: OKAY and a pulse, but data unchanged.
        p0 = pulse_cnt;
        wr32(32'h08, 32'h0000_0000, 4'b0000, r);
        check_eq("zstrb_bresp", 64'(r), 64'(2'b00));
        check_eq("zstrb_pulse", 64'(pulse_cnt - p0), 64'(1));
        check_eq("zstrb_reg2", 64'(reg_q32[2*32 +: 32]), 64'(exp_regs[2]));

        // W before AW, BREADY held low.
        bready = 1'b0;
        wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
        check_eq("wfirst_c0_wready", 64'(wready), 64'(1));
        tick();
        wvalid = 1'b0;
        check_eq("wfirst_c1", 64'({awready, wready}), 64'(2'b10));
        tick();
        check_eq("wfirst_c2_wready", 64'(wready), 64'(0));
        tick();
        check_eq("wfirst_c3_wready", 64'(wready), 64'(0));
        awaddr = 32'h0C; awvalid = 1'b1;
        check_eq("wfirst_c3_awready", 64'(awready), 64'(1));
        tick();
        awvalid = 1'b0;
        check_eq("wfirst_c4_bvalid", 64'(bvalid), 64'(0));
        tick();
        check_eq("wfirst_c5_b", 64'({bvalid, bresp}), 64'(3'b100));
        check_eq("wfirst_c5_reg_wr", 64'(reg_wr32), 64'(16'h0008));
        exp_regs[3] = 32'hCAFE_F00D;
        for (int c = 6; c < 8; c++) begin
            tick();
            check_eq($sformatf("wfirst_c%0d_b", c), 64'({bvalid, bresp}), 64'(3'b100));
            check_eq($sformatf("wfirst_c%0d_rdy", c), 64'({awready, wready}), 64'(0));
        end
        bready = 1'b1;
        tick();
        check_eq("wfirst_c8_bvalid", 64'(bvalid), 64'(0));
        check_eq("wfirst_c8_readies", 64'({awready, wready}), 64'(2'b11));

        // Last register is in range.
        wr32(32'h3C, 32'h0000_00A5, 4'b0001, r);
        check_eq("last_bresp", 64'(r), 64'(2'b00));
        exp_regs[15] = 32'h0000_00A5;
        rd32(32'h3C, d, r);
        check_eq("last_rdata", 64'(d), 64'(32'h0000_00A5));

        // Error decode: past-the-end and misaligned.
        p0 = pulse_cnt;
        wr32(32'h40, 32'hFFFF_FFFF, 4'hF, r);
        check_eq("err_oob_bresp", 64'(r), 64'(2'b10));
        wr32(32'h06, 32'hFFFF_FFFF, 4'hF, r);
        check_eq("err_mis_bresp", 64'(r), 64'(2'b10));
        check_eq("err_no_pulse", 64'(pulse_cnt - p0), 64'(0));
        rd32(32'h40, d, r);
        check_eq("err_rd_data", 64'(d), 64'(0));
        check_eq("err_rd_resp", 64'(r), 64'(2'b10));
        check_regs("err");

        // 64-bit build: reg 1 = 5, then a read hits the cycle a write of 0xA commits.
        awaddr64 = 32'h08; wdata64 = 64'h5; wstrb64 = 8'hFF;
        awvalid64 = 1'b1; wvalid64 = 1'b1; bready64 = 1'b1; rready64 = 1'b1;
        tick();
        awvalid64 = 1'b0; wvalid64 = 1'b0;
        tick();
        check_eq("w64_bvalid", 64'(bvalid64), 64'(1));
        check_eq("w64_reg_wr", 64'(reg_wr64), 64'(16'h0002));
        tick();
        check_eq("w64_reg1", reg_q64[64 +: 64], 64'h5);
        wdata64 = 64'hA; awvalid64 = 1'b1; wvalid64 = 1'b1;
        tick();
        awvalid64 = 1'b0; wvalid64 = 1'b0;
        araddr64 = 32'h08; arvalid64 = 1'b1;
        check_eq("col_arready", 64'(arready64), 64'(1));
        tick();
        arvalid64 = 1'b0;
        check_eq("col_rvalid", 64'(rvalid64), 64'(1));
        check_eq("col_rdata_old", rdata64, 64'h5);
        check_eq("col_rresp", 64'(rresp64), 64'(2'b00));
        check_eq("col_bvalid", 64'(bvalid64), 64'(1));
        check_eq("col_reg1_new", reg_q64[64 +: 64], 64'hA);
        tick();
        check_eq("col_rvalid_clr", 64'(rvalid64), 64'(0));
        arvalid64 = 1'b1;
        tick();
        arvalid64 = 1'b0;
        check_eq("col_rdata_new", rdata64, 64'hA);
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
